// File: rtl/pid_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pid_pkg
// Purpose  : Shared widths and helpers for the PID error decimator.
//            ERR_W  - width of (sample - setpoint), one bit wider than input.
//            ACC_W  - accumulator width; holds 2^decimLog2 errors without wrap.
//                     Gains one guard bit when PID_ERROR_DECIMATOR_ROUND_EN is
//                     defined to absorb the rounding offset.
//            clamp_s - signed clamp of a 64-bit value into [min_v, max_v].
// Macros   : PID_ERROR_DECIMATOR_ROUND_EN (optional round-half-up)
// Revision : 1.0 - initial release
// ============================================================================
package pid_pkg;

  function automatic int ERR_W(input int in_w);
    return in_w + 1;
  endfunction

  function automatic int ACC_W(input int in_w, input int dlog2);
`ifdef PID_ERROR_DECIMATOR_ROUND_EN
    return in_w + 2 + dlog2;
`else
    return in_w + 1 + dlog2;
`endif
  endfunction

  function automatic logic signed [63:0] clamp_s(input logic signed [63:0] value,
                                                 input logic signed [63:0] min_v,
                                                 input logic signed [63:0] max_v);
    if (value > max_v)      return max_v;
    else if (value < min_v) return min_v;
    else                    return value;
  endfunction

endpackage
`default_nettype wire

// File: rtl/signed_saturator.sv
`default_nettype none
// ============================================================================
// Module   : signed_saturator
// Purpose  : Combinational clamp of a signed inLen-bit value into
//            [minValue, maxValue], truncated to outLen bits, plus a flag that
//            is high whenever the clamp altered the value.
// Ports    : i_in  [inLen]  signed value to clamp
//            o_out [outLen] clamped value
//            o_sat          clamp was active
// Revision : 1.0 - initial release
// ============================================================================
module signed_saturator
  import pid_pkg::*;
#(
  parameter int inLen    = 20,
  parameter int outLen   = 16,
  parameter int maxValue = 32767,
  parameter int minValue = -32768
) (
  input  logic signed [inLen-1:0]  i_in,
  output logic signed [outLen-1:0] o_out,
  output logic                     o_sat
);

  logic signed [63:0] w_ext;
  logic signed [63:0] w_clamped;

  assign w_ext     = 64'(i_in);
  assign w_clamped = clamp_s(w_ext, 64'(minValue), 64'(maxValue));
  assign o_out     = w_clamped[outLen-1:0];
  assign o_sat     = (w_clamped != w_ext);

endmodule
`default_nettype wire

// File: rtl/pid_error_decimator.sv
`default_nettype none
// ============================================================================
// Module   : pid_error_decimator
// Purpose  : Subtracts a per-window latched setpoint from strobed ADC samples,
//            boxcar-averages 2^decimLog2 errors and emits one saturated word
//            per window with a single-cycle strobe.
// Ports    : clkIn        system clock (posedge)
//            rstnIn       asynchronous active-low reset
//            sampleIn     signed ADC sample
//            sampleStrobe sampleIn valid
//            setpointIn   signed loop setpoint (latched on first window sample)
//            clearIn      synchronous window abort (wins over sampleStrobe)
//            outWire      registered decimated error
//            outStrobe    one-cycle pulse on outWire update
//            satFlag      latest update was clamped
// Macros   : PID_ERROR_DECIMATOR_ROUND_EN - round-half-up instead of floor
// Revision : 1.0 - initial release
// ============================================================================
module pid_error_decimator
  import pid_pkg::*;
#(
  parameter int inBitDepth  = 16,
  parameter int outBitDepth = 16,
  parameter int decimLog2   = 3,
  parameter int maxValue    = 32767,
  parameter int minValue    = -32768
) (
  input  logic                          clkIn,
  input  logic                          rstnIn,
  input  logic signed [inBitDepth-1:0]  sampleIn,
  input  logic                          sampleStrobe,
  input  logic signed [inBitDepth-1:0]  setpointIn,
  input  logic                          clearIn,
  output logic signed [outBitDepth-1:0] outWire,
  output logic                          outStrobe,
  output logic                          satFlag
);

  localparam int EW = ERR_W(inBitDepth);
  localparam int AW = ACC_W(inBitDepth, decimLog2);

  logic signed [AW-1:0]          r_acc;
  logic        [decimLog2-1:0]   r_cnt;
  logic signed [inBitDepth-1:0]  r_sp;
  logic signed [outBitDepth-1:0] r_out;
  logic                          r_stb;
  logic                          r_sat;

  logic                          w_first;
  logic                          w_last;
  logic signed [inBitDepth-1:0]  w_sp;
  logic signed [EW-1:0]          w_err;
  logic signed [AW-1:0]          w_sum;
  logic signed [AW-1:0]          w_biased;
  logic signed [AW-1:0]          w_shifted;
  logic signed [outBitDepth-1:0] w_sat_out;
  logic                          w_sat_flag;

  assign w_first = (r_cnt == '0);
  // N is a power of two, so the last slot of the window is the all-ones count.
  assign w_last  = &r_cnt;

  // The first sample of a window sees the incoming setpoint directly.
  assign w_sp  = w_first ? setpointIn : r_sp;
  assign w_err = EW'(sampleIn) - EW'(w_sp);
  assign w_sum = r_acc + AW'(w_err);

`ifdef PID_ERROR_DECIMATOR_ROUND_EN
  localparam logic signed [AW-1:0] RND = AW'(1) << (decimLog2 - 1);
  assign w_biased = w_sum + RND;
`else
  assign w_biased = w_sum;
`endif

  // Arithmetic shift: floor division by N for negative sums.
  assign w_shifted = w_biased >>> decimLog2;

  signed_saturator #(
    .inLen    (AW),
    .outLen   (outBitDepth),
    .maxValue (maxValue),
    .minValue (minValue)
  ) u_sat (
    .i_in  (w_shifted),
    .o_out (w_sat_out),
    .o_sat (w_sat_flag)
  );

  always_ff @(posedge clkIn or negedge rstnIn) begin
    if (!rstnIn) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_sp  <= '0;
      r_out <= '0;
      r_stb <= 1'b0;
      r_sat <= 1'b0;
    end else if (clearIn) begin
      // Abort the window; the last published result stays visible.
      r_acc <= '0;
      r_cnt <= '0;
      r_stb <= 1'b0;
    end else if (sampleStrobe) begin
      if (w_first) begin
        r_sp <= setpointIn;
      end
      if (w_last) begin
        r_out <= w_sat_out;
        r_sat <= w_sat_flag;
        r_stb <= 1'b1;
        r_acc <= '0;
        r_cnt <= '0;
      end else begin
        r_acc <= w_sum;
        r_cnt <= r_cnt + 1'b1;
        r_stb <= 1'b0;
      end
    end else begin
      r_stb <= 1'b0;
    end
  end

  assign outWire   = r_out;
  assign outStrobe = r_stb;
  assign satFlag   = r_sat;

endmodule
`default_nettype wire

// File: tb/tb_pid_error_decimator.sv
`default_nettype none
// ============================================================================
// Module   : tb_pid_error_decimator
// Purpose  : Self-checking bench for pid_error_decimator (N = 8). Window
//            vectors from a table, hand-written corner sequences, then random
//            traffic against an arithmetic reference model of the averager.
// Macros   : PID_ERROR_DECIMATOR_ROUND_EN selects the rounded expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pid_error_decimator;

  localparam int N = 8;

  logic               clkIn = 1'b0;
  logic               rstnIn = 1'b0;
  logic signed [15:0] sampleIn = '0;
  logic               sampleStrobe = 1'b0;
  logic signed [15:0] setpointIn = '0;
  logic               clearIn = 1'b0;
  logic signed [15:0] outWire;
  logic               outStrobe;
  logic               satFlag;

  pid_error_decimator #(
    .inBitDepth  (16),
    .outBitDepth (16),
    .decimLog2   (3),
    .maxValue    (32767),
    .minValue    (-32768)
  ) dut (
    .clkIn        (clkIn),
    .rstnIn       (rstnIn),
    .sampleIn     (sampleIn),
    .sampleStrobe (sampleStrobe),
    .setpointIn   (setpointIn),
    .clearIn      (clearIn),
    .outWire      (outWire),
    .outStrobe    (outStrobe),
    .satFlag      (satFlag)
  );

  always #5 clkIn = ~clkIn;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: mean of the window's errors, then clamp.
  int     m_cnt;
  longint m_sum;
  int     m_sp;
  longint m_out;
  bit     m_stb;
  bit     m_sat;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic longint floor_div(input longint s, input longint d);
    longint q;
    q = s / d;
    if ((s % d) != 0 && s < 0) q = q - 1;
    return q;
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_sum = 0; m_sp = 0; m_out = 0; m_stb = 0; m_sat = 0;
  endtask

  task automatic model_clock(input int smp, input bit stb, input int sp, input bit clr);
    longint avg, cl;
    if (clr) begin
      m_cnt = 0; m_sum = 0; m_stb = 0;
    end else if (stb) begin
      if (m_cnt == 0) m_sp = sp;
      m_sum = m_sum + longint'(smp - m_sp);
      m_cnt++;
      if (m_cnt == N) begin
`ifdef PID_ERROR_DECIMATOR_ROUND_EN
        avg = floor_div(m_sum + N / 2, N);
`else
        avg = floor_div(m_sum, N);
`endif
        cl = (avg > 32767) ? 32767 : (avg < -32768) ? -32768 : avg;
        m_out = cl;
        m_sat = (cl != avg);
        m_stb = 1;
        m_sum = 0;
        m_cnt = 0;
      end else begin
        m_stb = 0;
      end
    end else begin
      m_stb = 0;
    end
  endtask

  // One clock: drive on negedge, model on posedge, compare 1 time unit later.
  task automatic step(input int smp, input bit stb, input int sp, input bit clr);
    @(negedge clkIn);
    sampleIn     = 16'(smp);
    sampleStrobe = stb;
    setpointIn   = 16'(sp);
    clearIn      = clr;
    @(posedge clkIn);
    model_clock(smp, stb, sp, clr);
    #1;
    check("model_strobe", longint'(outStrobe), longint'(m_stb));
    check("model_out", longint'(outWire), m_out);
    check("model_sat", longint'(satFlag), longint'(m_sat));
  endtask

  typedef struct {
    int sp;
    int base;
    int stp;
    int exp_f;
    int exp_r;
    bit sat;
  } win_vec_t;

  win_vec_t vecs[8];
  int pulses;
  int last_pulse;
  int sp_now;

  initial begin
    vecs[0] = '{100,    100,    0,  0,      0,      1'b0};
    vecs[1] = '{0,      1,      1,  4,      5,      1'b0};
    vecs[2] = '{-32768, 32767,  0,  32767,  32767,  1'b1};
    vecs[3] = '{0,      0,      0,  0,      0,      1'b0};
    vecs[4] = '{0,      -32768, 0,  -32768, -32768, 1'b0};
    vecs[5] = '{32767,  -32768, 0,  -32768, -32768, 1'b1};
    vecs[6] = '{10,     0,      -1, -14,    -13,    1'b0};
    vecs[7] = '{0,      5,      0,  5,      5,      1'b0};

    model_reset();
    repeat (2) @(posedge clkIn);
    #1;
    check("reset_out", longint'(outWire), 0);
    check("reset_strobe", longint'(outStrobe), 0);
    check("reset_sat", longint'(satFlag), 0);
    @(negedge clkIn);
    rstnIn = 1'b1;

    // Table-driven windows.
    for (int v = 0; v < 8; v++) begin
      for (int i = 0; i < N; i++) step(vecs[v].base + i * vecs[v].stp, 1'b1, vecs[v].sp, 1'b0);
      check($sformatf("vec%0d_strobe", v), longint'(outStrobe), 1);
`ifdef PID_ERROR_DECIMATOR_ROUND_EN
      check($sformatf("vec%0d_out", v), longint'(outWire), longint'(vecs[v].exp_r));
`else
      check($sformatf("vec%0d_out", v), longint'(outWire), longint'(vecs[v].exp_f));
`endif
      check($sformatf("vec%0d_sat", v), longint'(satFlag), longint'(vecs[v].sat));
      step(0, 1'b0, 0, 1'b0);
      check($sformatf("vec%0d_drop", v), longint'(outStrobe), 0);
    end

    // Back-to-back strobes: 64 samples -> 8 single-cycle pulses, 8 apart.
    pulses = 0;
    last_pulse = -1;
    for (int c = 0; c < 64; c++) begin
      step(c * 3 - 50, 1'b1, 7, 1'b0);
      if (outStrobe) begin
        if (last_pulse >= 0) check("b2b_spacing", longint'(c - last_pulse), 8);
        last_pulse = c;
        pulses++;
      end
    end
    check("b2b_pulses", longint'(pulses), 8);

    // Clear together with a strobe aborts the window.
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      step(1234, 1'b1, 0, 1'b0);
      if (outStrobe) pulses++;
    end
    step(1234, 1'b1, 0, 1'b1);
    if (outStrobe) pulses++;
    check("clear_no_pulse", longint'(pulses), 0);
    for (int i = 0; i < N; i++) step(0, 1'b1, 16, 1'b0);
    check("clear_next_out", longint'(outWire), -16);
    check("clear_next_strobe", longint'(outStrobe), 1);

    // Clear on the window-end sample discards it.
    for (int i = 0; i < N - 1; i++) step(500, 1'b1, 0, 1'b0);
    step(500, 1'b1, 0, 1'b1);
    check("clear_last_no_pulse", longint'(outStrobe), 0);
    check("clear_last_hold", longint'(outWire), -16);

    // Mid-window setpoint change is ignored until the next window.
    for (int i = 0; i < N; i++) step(0, 1'b1, (i < 3) ? 0 : 1000, 1'b0);
    check("sp_mid_out", longint'(outWire), 0);
    for (int i = 0; i < N; i++) step(0, 1'b1, 1000, 1'b0);
    check("sp_next_out", longint'(outWire), -1000);

    // Gaps between strobes hold state; then asynchronous reset mid-window.
    for (int i = 0; i < 3; i++) begin
      step(40, 1'b1, 0, 1'b0);
      step(0, 1'b0, 0, 1'b0);
    end
    @(negedge clkIn);
    #2;
    rstnIn = 1'b0;
    model_reset();
    #1;
    check("async_reset_out", longint'(outWire), 0);
    check("async_reset_sat", longint'(satFlag), 0);
    @(negedge clkIn);
    rstnIn = 1'b1;
    for (int i = 0; i < N; i++) step(24, 1'b1, 0, 1'b0);
    check("post_reset_out", longint'(outWire), 24);

    // Randomized traffic against the model.
    sp_now = 0;
    for (int c = 0; c < 1500; c++) begin
      int smp;
      bit stb, clr;
      case ($urandom_range(0, 3))
        0:       smp = 32767;
        1:       smp = -32768;
        default: smp = int'($urandom_range(0, 65535)) - 32768;
      endcase
      if ($urandom_range(0, 19) == 0) begin
        case ($urandom_range(0, 2))
          0:       sp_now = 32767;
          1:       sp_now = -32768;
          default: sp_now = int'($urandom_range(0, 65535)) - 32768;
        endcase
      end
      stb = ($urandom_range(0, 9) < 7);
      clr = ($urandom_range(0, 49) == 0);
      step(smp, stb, sp_now, clr);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
